// File: rtl/tmr_pkg.sv
// Shared definitions for the triple-redundant writeback register:
// stage states, copy count and the voted word width helper.
package tmr_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SCRUB = 2'd2
    } tmr_state_e;

    // Number of redundant copies held by the stage.
    localparam int unsigned NCOPIES = 3;

    // Default datapath width and the matching voted word ({zero, result}).
    localparam int unsigned DEFAULT_WIDTH  = 32;
    localparam int unsigned DEFAULT_VOTE_W = DEFAULT_WIDTH + 1;

    // Width of one stored copy for a given result width: result plus zero flag.
    function automatic int unsigned vote_width(input int unsigned width);
        return width + 1;
    endfunction

endpackage

// File: rtl/tmr_wb_reg_maj3_vote.sv
// Bitwise 2-of-3 majority voter. Also reports, per copy, whether that
// copy disagrees with the voted word in any bit.
module maj3_vote #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] vote_o,
    output logic [2:0]   mis_o
);

    // Majority per bit, then compare each copy against the result.
    always_comb begin
        vote_o   = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
        mis_o[0] = (a_i != vote_o);
        mis_o[1] = (b_i != vote_o);
        mis_o[2] = (c_i != vote_o);
    end

endmodule

// File: rtl/tmr_wb_reg.sv
// Triple-redundant writeback pipeline register with majority vote,
// scrub-on-mismatch and a saturating scrub-event counter.
// Optional fault-injection ports are compiled in with TMR_WB_INJECT_EN.
module tmr_wb_reg
    import tmr_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_result,
    input  logic                in_zero,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_result,
    output logic                out_zero,
    input  logic                clr_err,
    output logic [ERRCNT_W-1:0] err_count,
    output logic [2:0]          err_copy,
    output logic                fault_sat
`ifdef TMR_WB_INJECT_EN
    ,
    input  logic                inj_en,
    input  logic [1:0]          inj_copy,
    input  logic [WIDTH:0]      inj_mask
`endif
);

    localparam int unsigned VW = vote_width(WIDTH);

    tmr_state_e                   state_q, state_d;
    logic [NCOPIES-1:0][VW-1:0]   copy_q, copy_d;
    logic [ERRCNT_W-1:0]          err_count_q, err_count_d;
    logic [2:0]                   err_copy_q, err_copy_d;

    logic [VW-1:0]                vote;
    logic [2:0]                   mis_vec;
    logic                         mis;
    logic                         err_hit;
    logic                         inject_act;
    logic [VW-1:0]                in_word;

    assign in_word = {in_zero, in_result};

    maj3_vote #(.W(VW)) u_vote (
        .a_i    (copy_q[0]),
        .b_i    (copy_q[1]),
        .c_i    (copy_q[2]),
        .vote_o (vote),
        .mis_o  (mis_vec)
    );

    assign mis = |mis_vec;

`ifdef TMR_WB_INJECT_EN
    // An injection takes the place of vote/scrub for its cycle; copy 3 does not exist.
    assign inject_act = inj_en && (inj_copy != 2'd3) && (state_q == FULL);
`else
    assign inject_act = 1'b0;
`endif

    // Next-state, copy updates and handshake outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d   = state_q;
        copy_d    = copy_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        err_hit   = 1'b0;
        unique case (state_q)
            EMPTY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    for (int i = 0; i < NCOPIES; i++) copy_d[i] = in_word;
                    state_d = FULL;
                end
            end
            FULL: begin
                out_valid = 1'b1;
                if (inject_act) begin
`ifdef TMR_WB_INJECT_EN
                    for (int i = 0; i < NCOPIES; i++) begin
                        if (inj_copy == 2'(i)) copy_d[i] = copy_q[i] ^ inj_mask;
                    end
`endif
                    if (out_ready) state_d = EMPTY;
                end else if (mis) begin
                    for (int i = 0; i < NCOPIES; i++) copy_d[i] = vote;
                    err_hit = 1'b1;
                    state_d = out_ready ? EMPTY : SCRUB;
                end else begin
                    in_ready = out_ready;
                    if (out_ready) begin
                        if (in_valid) begin
                            for (int i = 0; i < NCOPIES; i++) copy_d[i] = in_word;
                        end else begin
                            state_d = EMPTY;
                        end
                    end
                end
            end
            SCRUB: begin
                out_valid = 1'b1;
                state_d   = out_ready ? EMPTY : FULL;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Error status: clear has priority over a coincident scrub event.
    always_comb begin
        err_count_d = err_count_q;
        err_copy_d  = err_copy_q;
        if (clr_err) begin
            err_count_d = '0;
            err_copy_d  = '0;
        end else if (err_hit) begin
            if (!(&err_count_q)) err_count_d = err_count_q + 1'b1;
            err_copy_d = err_copy_q | mis_vec;
        end
    end

    // State, copies and error status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            copy_q      <= '0;
            err_count_q <= '0;
            err_copy_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q     <= state_d;
            copy_q      <= copy_d;
            err_count_q <= err_count_d;
            err_copy_q  <= err_copy_d;
        end
    end

    assign out_result = vote[WIDTH-1:0];
    assign out_zero   = vote[WIDTH];
    assign err_count  = err_count_q;
    assign err_copy   = err_copy_q;
    assign fault_sat  = &err_count_q;

endmodule

// File: tb/tb_tmr_wb_reg.sv
// Directed self-checking bench for tmr_wb_reg. Uses ERRCNT_W=2 so counter
// saturation is reachable; injection scenarios need TMR_WB_INJECT_EN.
module tb_tmr_wb_reg;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned ERRCNT_W = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [WIDTH-1:0]    in_result = '0;
    logic                in_zero = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [WIDTH-1:0]    out_result;
    logic                out_zero;
    logic                clr_err = 1'b0;
    logic [ERRCNT_W-1:0] err_count;
    logic [2:0]          err_copy;
    logic                fault_sat;
`ifdef TMR_WB_INJECT_EN
    logic                inj_en = 1'b0;
    logic [1:0]          inj_copy = 2'd0;
    logic [WIDTH:0]      inj_mask = '0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tmr_wb_reg #(.WIDTH(WIDTH), .ERRCNT_W(ERRCNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_zero    (in_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .clr_err    (clr_err),
        .err_count  (err_count),
        .err_copy   (err_copy),
        .fault_sat  (fault_sat)
`ifdef TMR_WB_INJECT_EN
        ,
        .inj_en     (inj_en),
        .inj_copy   (inj_copy),
        .inj_mask   (inj_mask)
`endif
    );

    // Advance past the next rising edge and let outputs settle.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #10;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result got %h exp 0", out_result); end
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero got %b exp 0", out_zero); end
        checks++; if (err_count !== 2'd0) begin errors++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
        checks++; if (err_copy !== 3'b000) begin errors++; $display("FAIL reset_err_copy got %b exp 000", err_copy); end
        checks++; if (fault_sat !== 1'b0) begin errors++; $display("FAIL reset_fault_sat got %b exp 0", fault_sat); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_result = 32'h0000_0005; in_zero = 1'b0; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
        checks++; if (out_result !== 32'h5) begin errors++; $display("FAIL single_result got %h exp 5", out_result); end
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL single_zero got %b exp 0", out_zero); end
        checks++; if (err_count !== 2'd0) begin errors++; $display("FAIL single_err_count got %0d exp 0", err_count); end
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] vals [3];
        vals[0] = 32'h1; vals[1] = 32'h2; vals[2] = 32'h3;
        out_ready = 1'b1; in_valid = 1'b1; in_zero = 1'b0;
        in_result = vals[0];
        cycle();
        for (int i = 1; i < 3; i++) begin
            in_result = vals[i];
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", i, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_result !== vals[i-1]) begin
                errors++; $display("FAIL b2b_out[%0d] got v=%b %h exp v=1 %h", i, out_valid, out_result, vals[i-1]); end
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h3) begin
            errors++; $display("FAIL b2b_last got v=%b %h exp v=1 3", out_valid, out_result); end
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (out_result !== 32'h3 || out_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d] got v=%b %h exp v=1 3", i, out_valid, out_result); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %b exp 0", i, in_ready); end
        end
        out_ready = 1'b1;
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_boundary_values();
        // All-ones result with zero=0, then zero result with zero=1.
        out_ready = 1'b0; in_valid = 1'b1; in_result = 32'hFFFF_FFFF; in_zero = 1'b0;
        cycle();
        in_valid = 1'b0;
        #1;
        checks++; if (out_result !== 32'hFFFF_FFFF || out_zero !== 1'b0) begin
            errors++; $display("FAIL ones_out got %h z=%b exp ffffffff z=0", out_result, out_zero); end
        out_ready = 1'b1; in_valid = 1'b1; in_result = 32'h0; in_zero = 1'b1;
        cycle();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++; if (out_result !== 32'h0 || out_zero !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL zero_out got v=%b %h z=%b exp v=1 0 z=1", out_valid, out_result, out_zero); end
        out_ready = 1'b1;
        cycle();
        in_zero = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL boundary_drain got %b exp 0", out_valid); end
    endtask

`ifdef TMR_WB_INJECT_EN
    task automatic test_inject_scrub();
        out_ready = 1'b0; in_valid = 1'b1; in_result = 32'hA5A5_A5A5; in_zero = 1'b0;
        cycle();
        in_valid = 1'b0;
        inj_en = 1'b1; inj_copy = 2'd1; inj_mask = 33'h1;
        cycle();
        inj_en = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0 || out_result !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL inj_detect got rdy=%b %h exp rdy=0 a5a5a5a5", in_ready, out_result); end
        cycle();
        checks++; if (err_count !== 2'd1) begin errors++; $display("FAIL inj_err_count got %0d exp 1", err_count); end
        checks++; if (err_copy !== 3'b010) begin errors++; $display("FAIL inj_err_copy got %b exp 010", err_copy); end
        checks++; if (out_valid !== 1'b1 || out_result !== 32'hA5A5_A5A5 || in_ready !== 1'b0) begin
            errors++; $display("FAIL inj_scrub_out got v=%b rdy=%b %h exp v=1 rdy=0 a5a5a5a5", out_valid, in_ready, out_result); end
        cycle();
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL inj_consistent got %b exp 1", in_ready); end
        out_ready = 1'b0;
    endtask

    task automatic test_inject_clear();
        inj_en = 1'b1; inj_copy = 2'd2; inj_mask = 33'h1_0000_0000;
        cycle();
        inj_en = 1'b0; clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        checks++; if (err_count !== 2'd0 || err_copy !== 3'b000) begin
            errors++; $display("FAIL clr_wins got cnt=%0d copy=%b exp cnt=0 copy=000", err_count, err_copy); end
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL clr_vote_zero got %b exp 0", out_zero); end
        cycle();
        cycle();
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || err_count !== 2'd0) begin
            errors++; $display("FAIL clr_scrubbed got rdy=%b cnt=%0d exp rdy=1 cnt=0", in_ready, err_count); end
        out_ready = 1'b0;
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt;
        for (int k = 1; k <= 5; k++) begin
            inj_en = 1'b1; inj_copy = 2'((k - 1) % 3); inj_mask = 33'h1;
            cycle();
            inj_en = 1'b0;
            cycle();
            cycle();
            exp_cnt = (k > 3) ? 2'd3 : 2'(k);
            checks++; if (err_count !== exp_cnt) begin errors++; $display("FAIL sat_count[%0d] got %0d exp %0d", k, err_count, exp_cnt); end
        end
        checks++; if (fault_sat !== 1'b1) begin errors++; $display("FAIL sat_flag got %b exp 1", fault_sat); end
        checks++; if (err_copy !== 3'b111) begin errors++; $display("FAIL sat_err_copy got %b exp 111", err_copy); end
        inj_en = 1'b1; inj_copy = 2'd3; inj_mask = 33'h1;
        cycle();
        inj_en = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL inj_copy3_ignored got %b exp 1", in_ready); end
        cycle();
        out_ready = 1'b0;
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        checks++; if (err_count !== 2'd0 || fault_sat !== 1'b0) begin
            errors++; $display("FAIL sat_clear got cnt=%0d sat=%b exp 0 0", err_count, fault_sat); end
    endtask
`endif

    task automatic test_reset_mid_stall();
        out_ready = 1'b0; in_valid = 1'b1; in_result = 32'h0000_1234; in_zero = 1'b1;
        cycle();
        in_valid = 1'b0; in_zero = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h1234) begin
            errors++; $display("FAIL mid_pre got v=%b %h exp v=1 1234", out_valid, out_result); end
        #1 reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b exp 1", in_ready); end
        checks++; if (out_result !== 32'h0 || out_zero !== 1'b0) begin
            errors++; $display("FAIL mid_out_result got %h z=%b exp 0 z=0", out_result, out_zero); end
        @(negedge clk);
        reset = 1'b1;
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_discard got %b exp 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_boundary_values();
`ifdef TMR_WB_INJECT_EN
        test_inject_scrub();
        test_inject_clear();
        test_saturate();
`endif
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tmr_wb_reg.md
Name: tmr_wb_reg

Overview:
- Triple-redundant writeback pipeline register. It sits directly downstream of the voted ALU and upstream of the register-file write port.
- Captures the ALU {result, zero} pair under a valid/ready handshake. Stores three copies and presents a bitwise 2-of-3 majority to the consumer.
- Detects disagreement between copies, scrubs the copies back to the voted value, and counts the events for the fault-tolerance status path.

Parameters:
- WIDTH, 32, datapath width of the result.
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  ALU result valid.
- in_ready  out  1  stage can accept.
- in_result  in  WIDTH  ALU result.
- in_zero  in  1  ALU zero flag.
- out_valid  out  1  voted entry available.
- out_ready  in  1  consumer accepts.
- out_result  out  WIDTH  voted result.
- out_zero  out  1  voted zero flag.
- clr_err  in  1  synchronous clear of the error status.
- err_count  out  ERRCNT_W  saturating count of scrub events.
- err_copy  out  3  sticky per-copy disagreement flags.
- fault_sat  out  1  high when err_count is at its maximum.

Behaviour:
- Storage: copies c0, c1, c2, each {zero, result}, WIDTH+1 bits.
- Vote: v = (c0&c1)|(c0&c2)|(c1&c2), bitwise. out_result and out_zero are always driven from v, never from a raw copy.
- Mismatch: mis = (c0!=v)|(c1!=v)|(c2!=v), evaluated only in FULL.
- FSM states:
  - EMPTY: in_ready=1, out_valid=0. If in_valid, all three copies <= {in_zero, in_result}; next state FULL.
  - FULL, no mismatch: out_valid=1, in_ready=out_ready.
    - out_ready & in_valid: reload all copies; stay in FULL (back-to-back, one transfer per cycle).
    - out_ready & !in_valid: go to EMPTY.
    - !out_ready: hold.
  - FULL, mismatch: out_valid=1, in_ready=0. All copies <= v. Next state SCRUB if !out_ready, else EMPTY; the entry is consumed with its voted value.
    - err_count increments, saturating.
    - err_copy[i] sets for each copy i that differs from v.
  - SCRUB: one cycle. out_valid=1, in_ready=0, copies are now consistent. If out_ready, go to EMPTY; else go to FULL.
- Latency: one cycle from the in handshake to out_valid. Zero-bubble throughput when there are no mismatches.
- Handshakes:
  - A transfer occurs on a rising edge where valid & ready are both 1.
  - out_result and out_zero are stable while out_valid=1 and out_ready=0. A scrub does not change v, so the outputs stay stable through it.
- Error status:
  - clr_err zeroes err_count and err_copy next edge.
  - clr_err coincident with a mismatch: the clear wins and the event is not counted.
  - fault_sat = (err_count == all-ones).
- Reset (reset=0, asynchronous):
  - state=EMPTY, copies=0, err_count=0, err_copy=0.
  - Outputs: in_ready=1, out_valid=0, out_result=0, out_zero=0, fault_sat=0.
  - Reset mid-transfer discards the held entry.
- A double fault on the same bit is outvoted by design; it is not detected beyond the normal vote.

Optional Feature:
- Macro: TMR_WB_INJECT_EN.
- Defined:
  - Adds ports inj_en (in, 1), inj_copy (in, 2, values 0..2), and inj_mask (in, WIDTH+1).
  - When inj_en=1 and state is FULL, copy inj_copy <= copy ^ inj_mask next edge, with no vote or scrub that cycle.
  - inj_copy=3 is ignored.
- Undefined: these ports are absent and the storage has no injection logic.

Decomposition:
- Package tmr_pkg holds:
  - the state enum {EMPTY, FULL, SCRUB};
  - the vote-width constant (WIDTH+1);
  - the copy-count constant 3.
- One sub-module, maj3_vote: a parameterised combinational bitwise 2-of-3 voter with a per-copy mismatch vector output. It is reused for the data vote and the err_copy generation.

Test Plan:
- Reset, then send in_result=0x0000_0005, in_zero=0 with out_ready=1 -> out_valid is 1 on the next cycle with out_result=5, out_zero=0; err_count=0.
- Back-to-back stream 0x1,0x2,0x3 with out_ready=1 -> in_ready stays 1 and the outputs appear in order, one per cycle with no bubbles. Then hold out_ready=0 for 3 cycles -> out_result stays 0x3 and in_ready=0.
- (TMR_WB_INJECT_EN) Load 0xA5A5_A5A5, then inject inj_copy=1, inj_mask=0x1 with out_ready=0 -> the next cycle shows SCRUB; out_result stays 0xA5A5_A5A5; err_count=1; err_copy=3'b010.
- (TMR_WB_INJECT_EN) Inject on copy 2 and assert clr_err in the same detection cycle -> err_count=0 and err_copy=0, while the copies are still scrubbed (a following vote reports no mismatch).
- (TMR_WB_INJECT_EN, ERRCNT_W=2) Run 5 inject/scrub events -> err_count saturates at 3 and fault_sat=1.
- Assert reset low mid-stall in the FULL state -> out_valid drops immediately without waiting for a clock edge; in_ready=1; out_result=0.
